// File: rtl/cdb_arbiter_if.sv
// Producer/broadcast bundle for cdb_arbiter: ALU and LSB result inputs, their
// stall feedback, and the common data bus outputs.
interface cdb_arbiter_if #(
    parameter int DATA_W    = 32,
    parameter int ROB_POS_W = 4
);
    logic                 alu_valid;
    logic [DATA_W-1:0]    alu_val;
    logic [ROB_POS_W-1:0] alu_rob_pos;
    logic                 alu_stall;
    logic                 lsb_valid;
    logic [DATA_W-1:0]    lsb_val;
    logic [ROB_POS_W-1:0] lsb_rob_pos;
    logic                 lsb_stall;
    logic                 cdb_valid;
    logic [DATA_W-1:0]    cdb_val;
    logic [ROB_POS_W-1:0] cdb_rob_pos;
    logic                 cdb_src;

    modport master (
        output alu_valid, alu_val, alu_rob_pos, lsb_valid, lsb_val, lsb_rob_pos,
        input  alu_stall, lsb_stall, cdb_valid, cdb_val, cdb_rob_pos, cdb_src
    );

    modport slave (
        input  alu_valid, alu_val, alu_rob_pos, lsb_valid, lsb_val, lsb_rob_pos,
        output alu_stall, lsb_stall, cdb_valid, cdb_val, cdb_rob_pos, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-source result FIFOs with bypass, one broadcast per cycle.
// Optional macro CDB_ROUND_ROBIN_EN selects round-robin tie breaking (default: LSB wins).
module cdb_arbiter #(
    parameter int DEPTH     = 2,
    parameter int DATA_W    = 32,
    parameter int ROB_POS_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          rollback,
    cdb_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [DATA_W-1:0]    alu_val_mem_r [DEPTH];
    logic [ROB_POS_W-1:0] alu_pos_mem_r [DEPTH];
    logic [DATA_W-1:0]    lsb_val_mem_r [DEPTH];
    logic [ROB_POS_W-1:0] lsb_pos_mem_r [DEPTH];
    logic [PTR_W-1:0]     alu_head_r, alu_tail_r, lsb_head_r, lsb_tail_r;
    logic [CNT_W-1:0]     alu_cnt_r, lsb_cnt_r;
`ifdef CDB_ROUND_ROBIN_EN
    logic                 last_grant_r;
`endif

    logic alu_empty_s, lsb_empty_s, alu_acc_s, lsb_acc_s, alu_cand_s, lsb_cand_s;
    logic grant_alu_s, grant_lsb_s, alu_push_s, alu_pop_s, lsb_push_s, lsb_pop_s;
    logic [DATA_W-1:0]    win_val_s;
    logic [ROB_POS_W-1:0] win_pos_s;

    // Stall depends only on registered occupancy, so a same-cycle pop never releases it.
    assign bus.alu_stall = (alu_cnt_r == CNT_FULL);
    assign bus.lsb_stall = (lsb_cnt_r == CNT_FULL);

    // Candidate selection, grant decision and push/pop strobes.
    always_comb begin
        alu_empty_s = (alu_cnt_r == CNT_ZERO);
        lsb_empty_s = (lsb_cnt_r == CNT_ZERO);
        alu_acc_s   = bus.alu_valid & ~bus.alu_stall;
        lsb_acc_s   = bus.lsb_valid & ~bus.lsb_stall;
        alu_cand_s  = ~alu_empty_s | alu_acc_s;
        lsb_cand_s  = ~lsb_empty_s | lsb_acc_s;
        if (alu_cand_s && lsb_cand_s) begin
`ifdef CDB_ROUND_ROBIN_EN
            grant_lsb_s = ~last_grant_r;
`else
            grant_lsb_s = 1'b1;
`endif
            grant_alu_s = ~grant_lsb_s;
        end else begin
            grant_lsb_s = lsb_cand_s;
            grant_alu_s = alu_cand_s;
        end
        alu_pop_s  = grant_alu_s & ~alu_empty_s;
        lsb_pop_s  = grant_lsb_s & ~lsb_empty_s;
        // A granted input into an empty queue bypasses storage entirely.
        alu_push_s = alu_acc_s & ~(grant_alu_s & alu_empty_s);
        lsb_push_s = lsb_acc_s & ~(grant_lsb_s & lsb_empty_s);
        if (grant_lsb_s) begin
            if (lsb_empty_s) begin
                win_val_s = bus.lsb_val;
                win_pos_s = bus.lsb_rob_pos;
            end else begin
                win_val_s = lsb_val_mem_r[lsb_head_r];
                win_pos_s = lsb_pos_mem_r[lsb_head_r];
            end
        end else if (grant_alu_s) begin
            if (alu_empty_s) begin
                win_val_s = bus.alu_val;
                win_pos_s = bus.alu_rob_pos;
            end else begin
                win_val_s = alu_val_mem_r[alu_head_r];
                win_pos_s = alu_pos_mem_r[alu_head_r];
            end
        end else begin
            win_val_s = {DATA_W{1'b0}};
            win_pos_s = {ROB_POS_W{1'b0}};
        end
    end

    // Queue storage writes; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (!rst && !rollback && rdy) begin
            if (alu_push_s) begin
                alu_val_mem_r[alu_tail_r] <= bus.alu_val;
                alu_pos_mem_r[alu_tail_r] <= bus.alu_rob_pos;
            end
            if (lsb_push_s) begin
                lsb_val_mem_r[lsb_tail_r] <= bus.lsb_val;
                lsb_pos_mem_r[lsb_tail_r] <= bus.lsb_rob_pos;
            end
        end
    end

    // Pointer/count bookkeeping and the registered broadcast outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_head_r      <= {PTR_W{1'b0}};
            alu_tail_r      <= {PTR_W{1'b0}};
            lsb_head_r      <= {PTR_W{1'b0}};
            lsb_tail_r      <= {PTR_W{1'b0}};
            alu_cnt_r       <= CNT_ZERO;
            lsb_cnt_r       <= CNT_ZERO;
            bus.cdb_valid   <= 1'b0;
            bus.cdb_val     <= {DATA_W{1'b0}};
            bus.cdb_rob_pos <= {ROB_POS_W{1'b0}};
            bus.cdb_src     <= 1'b0;
`ifdef CDB_ROUND_ROBIN_EN
            last_grant_r    <= 1'b1;
`endif
        end else if (rollback) begin
            alu_head_r    <= {PTR_W{1'b0}};
            alu_tail_r    <= {PTR_W{1'b0}};
            lsb_head_r    <= {PTR_W{1'b0}};
            lsb_tail_r    <= {PTR_W{1'b0}};
            alu_cnt_r     <= CNT_ZERO;
            lsb_cnt_r     <= CNT_ZERO;
            bus.cdb_valid <= 1'b0;
`ifdef CDB_ROUND_ROBIN_EN
            last_grant_r  <= 1'b1;
`endif
        end else if (rdy) begin
            alu_head_r <= alu_head_r + PTR_W'(alu_pop_s);
            alu_tail_r <= alu_tail_r + PTR_W'(alu_push_s);
            lsb_head_r <= lsb_head_r + PTR_W'(lsb_pop_s);
            lsb_tail_r <= lsb_tail_r + PTR_W'(lsb_push_s);
            alu_cnt_r  <= alu_cnt_r + CNT_W'(alu_push_s) - CNT_W'(alu_pop_s);
            lsb_cnt_r  <= lsb_cnt_r + CNT_W'(lsb_push_s) - CNT_W'(lsb_pop_s);
            bus.cdb_valid <= grant_alu_s | grant_lsb_s;
            if (grant_alu_s || grant_lsb_s) begin
                bus.cdb_val     <= win_val_s;
                bus.cdb_rob_pos <= win_pos_s;
                bus.cdb_src     <= grant_lsb_s;
`ifdef CDB_ROUND_ROBIN_EN
                last_grant_r    <= grant_lsb_s;
`endif
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed plus randomized bench for cdb_arbiter, checked against a queue-based
// reference model of the broadcast rules.
module tb_cdb_arbiter;
    localparam int DEPTH = 2;
    localparam int DATA_W = 32;
    localparam int ROB_POS_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    logic rollback = 1'b0;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.DATA_W(DATA_W), .ROB_POS_W(ROB_POS_W)) bus ();

    cdb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_POS_W(ROB_POS_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail = 0;

    typedef logic [35:0] item_t;   // {rob_pos, value}
    item_t aq[$];
    item_t lq[$];
    logic        m_last;
    logic        e_valid;
    logic [31:0] e_val;
    logic [3:0]  e_pos;
    logic        e_src;

`ifdef CDB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 32'(bus.cdb_valid), 32'(e_valid));
        chk({tag, ".val"}, bus.cdb_val, e_val);
        chk({tag, ".pos"}, 32'(bus.cdb_rob_pos), 32'(e_pos));
        chk({tag, ".src"}, 32'(bus.cdb_src), 32'(e_src));
        chk({tag, ".alu_stall"}, 32'(bus.alu_stall), 32'(aq.size() == DEPTH));
        chk({tag, ".lsb_stall"}, 32'(bus.lsb_stall), 32'(lq.size() == DEPTH));
    endtask

    task automatic model_reset();
        aq.delete();
        lq.delete();
        m_last = 1'b1;
        e_valid = 1'b0;
        e_val = 32'd0;
        e_pos = 4'd0;
        e_src = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        bus.alu_valid = 1'b0; bus.alu_val = 32'd0; bus.alu_rob_pos = 4'd0;
        bus.lsb_valid = 1'b0; bus.lsb_val = 32'd0; bus.lsb_rob_pos = 4'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_outputs("reset");
    endtask

    // One clock: drive inputs, advance the reference model, then compare.
    task automatic step(input string tag, input logic r, input logic rb,
                        input logic av, input logic [31:0] aval, input logic [3:0] apos,
                        input logic lv, input logic [31:0] lval, input logic [3:0] lpos);
        logic a_acc, l_acc, a_c, l_c, win_lsb;
        item_t a_in, l_in, it;
        rdy = r; rollback = rb;
        bus.alu_valid = av; bus.alu_val = aval; bus.alu_rob_pos = apos;
        bus.lsb_valid = lv; bus.lsb_val = lval; bus.lsb_rob_pos = lpos;
        a_in = {apos, aval};
        l_in = {lpos, lval};
        if (rb) begin
            aq.delete();
            lq.delete();
            m_last = 1'b1;
            e_valid = 1'b0;
        end else if (r) begin
            a_acc = av && (aq.size() < DEPTH);
            l_acc = lv && (lq.size() < DEPTH);
            a_c = (aq.size() > 0) || a_acc;
            l_c = (lq.size() > 0) || l_acc;
            if (a_c && l_c) win_lsb = RR ? (m_last == 1'b0) : 1'b1;
            else            win_lsb = l_c;
            if (a_c || l_c) begin
                if (win_lsb) begin
                    if (lq.size() == 0) it = l_in;
                    else begin
                        it = lq.pop_front();
                        if (l_acc) lq.push_back(l_in);
                    end
                    if (a_acc) aq.push_back(a_in);
                end else begin
                    if (aq.size() == 0) it = a_in;
                    else begin
                        it = aq.pop_front();
                        if (a_acc) aq.push_back(a_in);
                    end
                    if (l_acc) lq.push_back(l_in);
                end
                e_valid = 1'b1;
                e_val = it[31:0];
                e_pos = it[35:32];
                e_src = win_lsb;
                m_last = win_lsb;
            end else begin
                e_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        check_outputs(tag);
    endtask

    initial begin
        int a_pend;
        int got_pos[$];
        logic av, lv, r, rb;

        // Reset values
        do_reset();

        // Single uncontended ALU result
        step("single", 1'b1, 1'b0, 1'b1, 32'h1234, 4'd3, 1'b0, 32'd0, 4'd0);
        chk("single.const_val", bus.cdb_val, 32'h1234);
        chk("single.const_pos", 32'(bus.cdb_rob_pos), 32'd3);
        step("single_idle", 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
        chk("single.pulse", 32'(bus.cdb_valid), 32'd0);

        // Simultaneous results: tie breaking
        do_reset();
        step("sim0", 1'b1, 1'b0, 1'b1, 32'hA, 4'd1, 1'b1, 32'hB, 4'd2);
        chk("sim.first_src", 32'(bus.cdb_src), RR ? 32'd0 : 32'd1);
        step("sim1", 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
        chk("sim.second_src", 32'(bus.cdb_src), RR ? 32'd1 : 32'd0);
        chk("sim.second_valid", 32'(bus.cdb_valid), 32'd1);
        step("sim2", 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);

        // Backpressure: LSB every cycle, ALU producer honours stall
        do_reset();
        a_pend = 0;
        for (int i = 0; i < 8; i++) begin
            av = (a_pend < 3) && !bus.alu_stall;
            step("bp", 1'b1, 1'b0, av, 32'hA0 + 32'(a_pend), 4'(8 + a_pend),
                 1'b1, 32'h100 + 32'(i), 4'(i));
            if (av) a_pend++;
            if (i == 1 && !RR) chk("bp.stall_at_two", 32'(bus.alu_stall), 32'd1);
        end
        for (int i = 0; i < 6; i++) begin
            av = (a_pend < 3) && !bus.alu_stall;
            step("bp_drain", 1'b1, 1'b0, av, 32'hA0 + 32'(a_pend), 4'(8 + a_pend),
                 1'b0, 32'd0, 4'd0);
            if (av) a_pend++;
        end

        // Rollback with queued entries, asserted while rdy is low
        do_reset();
        for (int i = 0; i < 3; i++)
            step("rb_fill", 1'b1, 1'b0, !bus.alu_stall, 32'hC0 + 32'(i), 4'(i),
                 !bus.lsb_stall, 32'hD0 + 32'(i), 4'(i + 4));
        step("rb_pulse", 1'b0, 1'b1, 1'b1, 32'hEE, 4'd9, 1'b1, 32'hFF, 4'd10);
        chk("rb.valid_low", 32'(bus.cdb_valid), 32'd0);
        chk("rb.alu_stall_low", 32'(bus.alu_stall), 32'd0);
        for (int i = 0; i < 3; i++)
            step("rb_idle", 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);

        // rdy low freezes everything, including queued entries
        do_reset();
        step("rdy_fill0", 1'b1, 1'b0, 1'b1, 32'h11, 4'd1, 1'b1, 32'h22, 4'd2);
        step("rdy_fill1", 1'b1, 1'b0, 1'b1, 32'h12, 4'd3, 1'b1, 32'h23, 4'd4);
        for (int i = 0; i < 3; i++)
            step("rdy_low", 1'b0, 1'b0, 1'b1, 32'h99, 4'd7, 1'b1, 32'h98, 4'd8);
        for (int i = 0; i < 4; i++)
            step("rdy_drain", 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);

        // Pointer wrap: five ALU results with LSB contention every other cycle
        do_reset();
        a_pend = 0;
        got_pos.delete();
        for (int i = 0; i < 20; i++) begin
            av = (a_pend < 5) && !bus.alu_stall;
            step("wrap", 1'b1, 1'b0, av, 32'h500 + 32'(a_pend), 4'(a_pend),
                 (i % 2) == 0, 32'h600 + 32'(i), 4'd15);
            if (av) a_pend++;
            if (bus.cdb_valid && !bus.cdb_src) got_pos.push_back(int'(bus.cdb_rob_pos));
        end
        chk("wrap.count", 32'(got_pos.size()), 32'd5);
        for (int i = 0; i < got_pos.size() && i < 5; i++)
            chk("wrap.order", 32'(got_pos[i]), 32'(i));

        // Randomized traffic including rdy gaps, rollbacks and stall violations
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom % 10) != 0;
            rb = ($urandom % 50) == 0;
            av = ($urandom % 3) != 0;
            lv = ($urandom % 3) != 0;
            if (bus.alu_stall && ($urandom % 10) != 0) av = 1'b0;
            if (bus.lsb_stall && ($urandom % 10) != 0) lv = 1'b0;
            step("rand", r, rb, av, $urandom, 4'($urandom), lv, $urandom, 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
